// File: rtl/por_event_framer.sv
// por_event_framer: turns veto / attention-change events from the FPT core
// into timestamped 7-byte frames for a byte-wide UART relay. Events are
// buffered in a small FIFO. A three-state FSM (IDLE/LOAD/SEND) serialises
// the buffered events one frame at a time.
//
// tx handshake: a byte transfers on a rising edge where tx_valid=1 and
// tx_ready=1. While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold.
// tx_valid never drops without a transfer, except on reset.
module por_event_framer #(
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic        clk_100mhz,
   input  logic        rst,
   input  logic        veto_in,
   input  logic [1:0]  attention_level,
   input  logic [15:0] motor_correction,
   input  logic        sensor_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        fifo_overflow,
   output logic [15:0] event_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = 35;  // {type, attn[1:0], corr[15:0], ts[15:0]}

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;

   logic [1:0]    state;
   logic [15:0]   ts;
   logic          veto_d;
   logic [1:0]    attn_d;
   logic [RW-1:0] mem [0:FIFO_DEPTH-1];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [RW-1:0] frame_rec;
   logic [2:0]    byte_idx;
   logic [3:0]    seq;

   logic          fifo_empty;
   logic          fifo_full;
   logic          veto_evt;
   logic          attn_evt;
   logic          evt;
   logic          push;
   logic          pop;
   logic [RW-1:0] new_rec;
   logic [7:0]    b1;
   logic [7:0]    chk;
   logic [2:0]    next_idx;
   logic [7:0]    next_byte;

   // The pointers carry one extra wrap bit. This lets a full FIFO be told apart from an empty one.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A veto and an attention change in the same cycle make one veto record.
   assign veto_evt = veto_in & ~veto_d;
   assign attn_evt = sensor_valid & (attention_level != attn_d);
   assign evt      = veto_evt | attn_evt;
   assign push     = evt & ~fifo_full;
   assign pop      = (state == ST_IDLE) & ~fifo_empty;
   assign new_rec  = {veto_evt, attention_level, motor_correction, ts};

   // These are the frame fields for the record currently held in the frame register.
   assign b1       = {seq, 1'b0, frame_rec[34], frame_rec[33:32]};
   assign chk      = b1 ^ frame_rec[31:24] ^ frame_rec[23:16] ^
                     frame_rec[15:8] ^ frame_rec[7:0];
   assign next_idx = byte_idx + 3'd1;

   // Select the byte that follows the one being offered now.
   always_comb begin
      next_byte = SYNC_BYTE;
      case (next_idx)
         3'd1:    next_byte = b1;
         3'd2:    next_byte = frame_rec[31:24];
         3'd3:    next_byte = frame_rec[23:16];
         3'd4:    next_byte = frame_rec[15:8];
         3'd5:    next_byte = frame_rec[7:0];
         3'd6:    next_byte = chk;
         default: next_byte = SYNC_BYTE;
      endcase
   end

   // Free-running timestamp, plus registered copies of the event inputs for edge detection.
   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         ts     <= 16'd0;
         veto_d <= 1'b0;
         attn_d <= 2'd0;
      end else begin
         ts     <= ts + 16'd1;
         veto_d <= veto_in;
         attn_d <= attention_level;
      end
   end

   // FIFO storage. It is not reset, because the pointers alone define which entries are valid.
   always_ff @(posedge clk_100mhz) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= new_rec;
      end
   end

   // FIFO pointers, accepted-event counter and the sticky drop flag.
   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         event_count   <= 16'd0;
         fifo_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr      <= wr_ptr + 1'b1;
            event_count <= event_count + 16'd1;
         end
         // Fullness is judged at the start of the cycle, so a pop in the same cycle does not save the event.
         if (evt && fifo_full) begin
            fifo_overflow <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Frame FSM: pop a record, present the sync byte, then walk bytes 1..6 on each handshake.
   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         state     <= ST_IDLE;
         frame_rec <= '0;
         byte_idx  <= 3'd0;
         seq       <= 4'd0;
         tx_valid  <= 1'b0;
         tx_data   <= 8'h00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  frame_rec <= mem[rd_ptr[AW-1:0]];
                  state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               byte_idx <= 3'd0;
               tx_valid <= 1'b1;
               tx_data  <= SYNC_BYTE;
               state    <= ST_SEND;
            end
            ST_SEND: begin
               if (tx_ready) begin
                  if (byte_idx == 3'd6) begin
                     tx_valid <= 1'b0;
                     tx_data  <= 8'h00;
                     seq      <= seq + 4'd1;
                     state    <= ST_IDLE;
                  end else begin
                     byte_idx <= next_idx;
                     tx_data  <= next_byte;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_por_event_framer.sv
// Directed bench for por_event_framer. It drives a table of single-cycle
// event vectors, followed by hand-written multi-cycle sequences: latency,
// back-pressure stall, reset mid-frame, seq wrap and FIFO overflow.
module tb_por_event_framer;

   logic        clk_100mhz = 1'b0;
   logic        rst = 1'b1;
   logic        veto_in;
   logic [1:0]  attention_level;
   logic [15:0] motor_correction;
   logic        sensor_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        fifo_overflow;
   logic [15:0] event_count;

   int total = 0;
   int bad   = 0;

   logic [15:0] tb_ts;
   logic [34:0] exp_q[$];
   logic [3:0]  exp_seq;
   logic [15:0] exp_count;
   logic [55:0] capf;
   int          capn;

   typedef struct {
      logic        v;
      logic [1:0]  a;
      logic        sv;
      logic [15:0] c;
      bit          frame;
      logic        t;
   } vec_t;

   vec_t vecs[6];

   por_event_framer #(.FIFO_DEPTH(8), .SYNC_BYTE(8'hA5)) dut (
      .clk_100mhz       (clk_100mhz),
      .rst              (rst),
      .veto_in          (veto_in),
      .attention_level  (attention_level),
      .motor_correction (motor_correction),
      .sensor_valid     (sensor_valid),
      .tx_ready         (tx_ready),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .fifo_overflow    (fifo_overflow),
      .event_count      (event_count)
   );

   // Clock and the bench's own copy of the timestamp.
   always #5 clk_100mhz = ~clk_100mhz;

   always @(posedge clk_100mhz) begin
      if (rst) tb_ts <= 16'd0;
      else     tb_ts <= tb_ts + 16'd1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [55:0] make_frame(input logic [3:0] s, input logic [34:0] r);
      logic [7:0] b1, b2, b3, b4, b5;
      b1 = {s, 1'b0, r[34], r[33:32]};
      b2 = r[31:24];
      b3 = r[23:16];
      b4 = r[15:8];
      b5 = r[7:0];
      return {8'hA5, b1, b2, b3, b4, b5, b1 ^ b2 ^ b3 ^ b4 ^ b5};
   endfunction

   // Present an event for exactly one cycle. Return the timestamp of that cycle.
   task automatic pulse(input logic v, input logic [1:0] a, input logic sv,
                        input logic [15:0] c, output logic [15:0] ts_at);
      veto_in          = v;
      attention_level  = a;
      sensor_valid     = sv;
      motor_correction = c;
      ts_at            = tb_ts;
      @(posedge clk_100mhz);
      #1;
      veto_in      = 1'b0;
      sensor_valid = 1'b0;
   endtask

   // Call this at a negedge. It collects accepted bytes until stop_at bytes are taken,
   // and returns at the negedge where the next byte is present.
   // If stall_at >= 0, tx_ready is held low for 10 cycles while that byte is offered.
   task automatic capture(input int stop_at, input int stall_at, output bit ok);
      int         stall;
      int         changes;
      logic [7:0] hd;
      stall = stall_at;
      capn  = 0;
      capf  = '0;
      ok    = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (capn == stop_at) begin
            ok = 1'b1;
            break;
         end
         if (tx_valid && (capn == stall)) begin
            tx_ready = 1'b0;
            hd       = tx_data;
            changes  = 0;
            repeat (10) begin
               @(negedge clk_100mhz);
               if (!tx_valid || (tx_data !== hd)) changes++;
            end
            check("stall_hold", changes, 0);
            tx_ready = 1'b1;
            stall    = -1;
         end
         if (tx_valid && tx_ready) begin
            capf = {capf[47:0], tx_data};
            capn++;
         end
         @(negedge clk_100mhz);
      end
   endtask

   task automatic check_frame(input string name, input logic [3:0] s, input logic [34:0] r);
      check({name, "_frame"}, capf, make_frame(s, r));
      check({name, "_xor"}, capf[7:0],
            capf[47:40] ^ capf[39:32] ^ capf[31:24] ^ capf[23:16] ^ capf[15:8]);
   endtask

   task automatic wait_quiet(input string name, input int n);
      int hi;
      hi = 0;
      repeat (n) begin
         @(negedge clk_100mhz);
         if (tx_valid) hi++;
      end
      check(name, hi, 0);
   endtask

   initial begin
      bit          ok;
      logic [15:0] ts_at;
      logic [34:0] rec;

      veto_in          = 1'b0;
      attention_level  = 2'd0;
      sensor_valid     = 1'b0;
      motor_correction = 16'h0000;
      tx_ready         = 1'b1;

      vecs[0] = '{v: 1'b0, a: 2'd3, sv: 1'b1, c: 16'hBEEF, frame: 1'b1, t: 1'b0};
      vecs[1] = '{v: 1'b0, a: 2'd1, sv: 1'b0, c: 16'h0000, frame: 1'b0, t: 1'b0};
      vecs[2] = '{v: 1'b0, a: 2'd1, sv: 1'b1, c: 16'h1111, frame: 1'b0, t: 1'b0};
      vecs[3] = '{v: 1'b1, a: 2'd0, sv: 1'b1, c: 16'h8001, frame: 1'b1, t: 1'b1};
      vecs[4] = '{v: 1'b1, a: 2'd0, sv: 1'b0, c: 16'hFFFF, frame: 1'b1, t: 1'b1};
      vecs[5] = '{v: 1'b0, a: 2'd2, sv: 1'b1, c: 16'h00FF, frame: 1'b1, t: 1'b0};

      // Reset state
      repeat (3) @(posedge clk_100mhz);
      @(negedge clk_100mhz);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_event_count", event_count, 16'h0000);
      check("rst_overflow", fifo_overflow, 1'b0);
      @(posedge clk_100mhz);
      #1;
      rst = 1'b0;

      // Veto at ts=0x10 with attn=2 and corr=0x1234; byte0 must appear 3 cycles later
      while (tb_ts != 16'h0010) begin
         @(posedge clk_100mhz);
         #1;
      end
      pulse(1'b1, 2'd2, 1'b0, 16'h1234, ts_at);
      @(negedge clk_100mhz);
      check("lat_n1_valid", tx_valid, 1'b0);
      @(negedge clk_100mhz);
      check("lat_n2_valid", tx_valid, 1'b0);
      @(negedge clk_100mhz);
      check("lat_n3_valid", tx_valid, 1'b1);
      check("lat_n3_sync", tx_data, 8'hA5);
      capture(7, -1, ok);
      check("first_capture_done", ok, 1'b1);
      check_frame("first", 4'd0, {1'b1, 2'd2, 16'h1234, 16'h0010});
      check("first_gap_valid", tx_valid, 1'b0);
      check("first_event_count", event_count, 16'd1);
      exp_seq   = 4'd1;
      exp_count = 16'd1;

      // Table-driven single-cycle events
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_100mhz);
         #1;
         pulse(vecs[i].v, vecs[i].a, vecs[i].sv, vecs[i].c, ts_at);
         if (vecs[i].frame) begin
            @(negedge clk_100mhz);
            capture(7, -1, ok);
            check($sformatf("vec%0d_done", i), ok, 1'b1);
            check_frame($sformatf("vec%0d", i), exp_seq,
                        {vecs[i].t, vecs[i].a, vecs[i].c, ts_at});
            exp_seq   = exp_seq + 4'd1;
            exp_count = exp_count + 16'd1;
         end else begin
            wait_quiet($sformatf("vec%0d_quiet", i), 10);
         end
         check($sformatf("vec%0d_count", i), event_count, exp_count);
      end

      // Back-pressure stall while byte3 is offered
      @(posedge clk_100mhz);
      #1;
      pulse(1'b1, 2'd3, 1'b0, 16'hC0DE, ts_at);
      @(negedge clk_100mhz);
      capture(7, 3, ok);
      check("stall_done", ok, 1'b1);
      check_frame("stall", exp_seq, {1'b1, 2'd3, 16'hC0DE, ts_at});
      exp_seq = exp_seq + 4'd1;

      // Reset during byte3. The aborted frame must not resume. Then an event in
      // the first cycle after release is compared against attn_d=0 and ts=0.
      @(posedge clk_100mhz);
      #1;
      pulse(1'b1, 2'd3, 1'b0, 16'h5A5A, ts_at);
      @(negedge clk_100mhz);
      capture(3, -1, ok);
      check("abort_reach_b3", ok, 1'b1);
      check("abort_b3_valid", tx_valid, 1'b1);
      rst = 1'b1;
      @(negedge clk_100mhz);
      check("abort_tx_valid", tx_valid, 1'b0);
      check("abort_tx_data", tx_data, 8'h00);
      check("abort_event_count", event_count, 16'd0);
      attention_level = 2'd1;
      sensor_valid    = 1'b1;
      @(posedge clk_100mhz);
      #1;
      rst = 1'b0;
      @(posedge clk_100mhz);
      #1;
      sensor_valid = 1'b0;
      @(negedge clk_100mhz);
      capture(7, -1, ok);
      check("post_rst_done", ok, 1'b1);
      check_frame("post_rst", 4'd0, {1'b0, 2'd1, 16'h5A5A, 16'h0000});
      exp_seq   = 4'd1;
      exp_count = 16'd1;

      // Sixteen more frames. Frame 17 must wrap seq to 0.
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk_100mhz);
         #1;
         pulse(1'b1, 2'd1, 1'b0, 16'h1000 + 16'(k), ts_at);
         @(negedge clk_100mhz);
         capture(7, -1, ok);
         check($sformatf("seq%0d_done", k), ok, 1'b1);
         check_frame($sformatf("seq%0d", k), exp_seq, {1'b1, 2'd1, 16'h1000 + 16'(k), ts_at});
         exp_seq   = exp_seq + 4'd1;
         exp_count = exp_count + 16'd1;
      end
      check("seq_wrap_b1", capf[47:44], 4'h0);
      check("seq_run_count", event_count, exp_count);

      // Overflow: 10 back-to-back events with tx_ready=0. The first event is popped into
      // the frame register at once, so 1 + 8 events are accepted and the 10th is dropped.
      rst      = 1'b1;
      tx_ready = 1'b0;
      attention_level = 2'd0;
      repeat (2) @(posedge clk_100mhz);
      #1;
      rst = 1'b0;
      @(posedge clk_100mhz);
      #1;
      check("ovf_pre_flag", fifo_overflow, 1'b0);
      for (int i = 0; i < 10; i++) begin
         attention_level  = (i % 2 == 1) ? 2'd2 : 2'd1;
         sensor_valid     = 1'b1;
         motor_correction = 16'h0A00 + 16'(i);
         if (i < 9) exp_q.push_back({1'b0, attention_level, motor_correction, tb_ts});
         @(posedge clk_100mhz);
         #1;
      end
      sensor_valid = 1'b0;
      @(negedge clk_100mhz);
      check("ovf_event_count", event_count, 16'd9);
      check("ovf_flag", fifo_overflow, 1'b1);
      tx_ready = 1'b1;
      for (int f = 0; f < 9; f++) begin
         capture(7, -1, ok);
         check($sformatf("ovf%0d_done", f), ok, 1'b1);
         rec = exp_q.pop_front();
         check_frame($sformatf("ovf%0d", f), 4'(f), rec);
      end
      wait_quiet("ovf_no_extra", 20);
      check("ovf_flag_sticky", fifo_overflow, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
